// File: rtl/fifo_rd_fwft.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_fwft
// Purpose  : Read-domain controller of an asynchronous FIFO. Owns the
//            binary/Gray read pointer and the registered empty flag, drives
//            the address of the asynchronous-read FIFO memory and presents a
//            first-word-fall-through valid/ready output stage built from a
//            single output register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   rclk       in   1     read-domain clock
//   rrst_n     in   1     asynchronous active-low reset
//   rq2_wptr   in   AW+1  Gray write pointer, already synchronised into rclk
//   rdata_mem  in   DW    memory read data (combinational function of raddr)
//   raddr      out  AW    memory read address
//   rptr       out  AW+1  registered Gray read pointer (to the wclk synchroniser)
//   rempty     out  1     registered: no unfetched word in memory
//   rlevel     out  AW+1  registered count of unfetched words in memory
//   out_data   out  DW    output data register
//   out_valid  out  1     out_data holds a valid word
//   out_ready  in   1     consumer accepts out_data when out_valid=1
// ============================================================================
module fifo_rd_fwft #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic [AW:0]   rq2_wptr,
  input  logic [DW-1:0] rdata_mem,
  output logic [AW-1:0] raddr,
  output logic [AW:0]   rptr,
  output logic          rempty,
  output logic [AW:0]   rlevel,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  // Output stage: IDLE means the output register is empty, HOLD means it
  // carries a word the consumer has not yet accepted.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     rbin_q, rbin_d;
  logic [AW:0]     rgray_q, rgray_d;
  logic [AW:0]     rlevel_q, rlevel_d;
  logic            rempty_q, rempty_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            fetch;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pointer, empty flag and level. The level is computed against the
  // post-fetch pointer so it matches what rempty will report next cycle.
  always_comb begin
    fetch    = !rempty_q && ((state_q == S_IDLE) || out_ready);
    rbin_d   = rbin_q + {{AW{1'b0}}, fetch};
    rgray_d  = (rbin_d >> 1) ^ rbin_d;
    // Full AW+1-bit Gray compare: equal pointers including the wrap bit
    // means nothing is left to fetch.
    rempty_d = (rgray_d == rq2_wptr);
    rlevel_d = gray2bin(rq2_wptr) - rbin_d;
  end

  // Output-stage next state. A fetch always reloads the output register,
  // whether the stage was empty or its word is being popped this cycle.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (fetch) begin
          out_data_d = rdata_mem;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (fetch) begin
            out_data_d = rdata_mem;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= S_IDLE;
      rbin_q     <= '0;
      rgray_q    <= '0;
      rempty_q   <= 1'b1;
      rlevel_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      rempty_q   <= rempty_d;
      rlevel_q   <= rlevel_d;
      out_data_q <= out_data_d;
    end
  end

  assign raddr     = rbin_q[AW-1:0];
  assign rptr      = rgray_q;
  assign rempty    = rempty_q;
  assign rlevel    = rlevel_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_fwft
// Purpose  : Self-checking bench for fifo_rd_fwft (DW=8, AW=4). Provides the
//            asynchronous-read memory and the write pointer, and compares the
//            DUT against fixed vectors and a word-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_fwft;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          rclk;
  logic          rrst_n;
  logic [AW:0]   rq2_wptr;
  logic [DW-1:0] rdata_mem;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [AW:0]   rlevel;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  logic [DW-1:0] mem [DEPTH];

  fifo_rd_fwft #(.DW(DW), .AW(AW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rdata_mem (rdata_mem),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rlevel    (rlevel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign rdata_mem = mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- reference model (word counts + data queue) -------------
  int            m_wr;       // words made visible through rq2_wptr
  int            m_fetched;  // words moved from memory into the output reg
  bit            m_valid;
  bit            m_empty;
  logic [DW-1:0] m_data;
  logic [DW-1:0] exp_q [$];

  task automatic model_reset();
    m_wr = 0; m_fetched = 0; m_valid = 0; m_empty = 1; m_data = '0;
    exp_q.delete();
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    mem[m_wr % DEPTH] = d;
    exp_q.push_back(d);
    m_wr++;
    rq2_wptr = gray(5'(m_wr % 32));
  endtask

  task automatic model_edge(input bit rdy);
    bit f;
    f = !m_empty && (!m_valid || rdy);
    if (f) begin
      m_data = exp_q.pop_front();
      m_valid = 1;
      m_fetched++;
    end else if (rdy) begin
      m_valid = 0;
    end
    m_empty = (m_wr == m_fetched);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, int'(out_valid), int'(m_valid));
    if (m_valid) chk({tag, ".data"}, int'(out_data), int'(m_data));
    chk({tag, ".empty"}, int'(rempty), int'(m_empty));
    chk({tag, ".level"}, int'(rlevel), m_wr - m_fetched);
    chk({tag, ".rptr"}, int'(rptr), int'(gray(5'(m_fetched % 32))));
    chk({tag, ".raddr"}, int'(raddr), m_fetched % DEPTH);
  endtask

  task automatic rstep(input bit rdy, input string tag);
    out_ready = rdy;
    @(posedge rclk);
    model_edge(rdy);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    rq2_wptr = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic [AW:0]   wbin;
    logic          rdy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_empty;
    logic [AW:0]   e_level;
    logic [AW:0]   e_rptr;
    int            rst_before;
  } vec_t;

  vec_t vt [18];

  initial begin
    // back-to-back read of three words
    vt[0]  = '{5'd3, 1'b1, 1'b0, 8'h00, 1'b0, 5'd3, 5'h00, 1};
    vt[1]  = '{5'd3, 1'b1, 1'b1, 8'hA0, 1'b0, 5'd2, 5'h01, 0};
    vt[2]  = '{5'd3, 1'b1, 1'b1, 8'hA1, 1'b0, 5'd1, 5'h03, 0};
    vt[3]  = '{5'd3, 1'b1, 1'b1, 8'hA2, 1'b1, 5'd0, 5'h02, 0};
    vt[4]  = '{5'd3, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 5'h02, 0};
    // consumer stalled: one fetch only, word held, then drained gap-free
    vt[5]  = '{5'd3, 1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 5'h00, 1};
    vt[6]  = '{5'd3, 1'b0, 1'b1, 8'hA0, 1'b0, 5'd2, 5'h01, 0};
    vt[7]  = '{5'd3, 1'b0, 1'b1, 8'hA0, 1'b0, 5'd2, 5'h01, 0};
    vt[8]  = '{5'd3, 1'b0, 1'b1, 8'hA0, 1'b0, 5'd2, 5'h01, 0};
    vt[9]  = '{5'd3, 1'b1, 1'b1, 8'hA1, 1'b0, 5'd1, 5'h03, 0};
    vt[10] = '{5'd3, 1'b1, 1'b1, 8'hA2, 1'b1, 5'd0, 5'h02, 0};
    vt[11] = '{5'd3, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 5'h02, 0};
    // new word appears while a word is being popped: no bubble, no duplicate
    vt[12] = '{5'd4, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 5'h02, 0};
    vt[13] = '{5'd4, 1'b1, 1'b1, 8'hA3, 1'b1, 5'd0, 5'h06, 0};
    vt[14] = '{5'd5, 1'b0, 1'b1, 8'hA3, 1'b0, 5'd1, 5'h06, 0};
    vt[15] = '{5'd6, 1'b1, 1'b1, 8'hA4, 1'b0, 5'd1, 5'h07, 0};
    vt[16] = '{5'd6, 1'b1, 1'b1, 8'hA5, 1'b1, 5'd0, 5'h05, 0};
    vt[17] = '{5'd6, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 5'h05, 0};

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hA0 + i);
    model_reset();

    // ---- reset state, stable for 10 clocks --------------------------------
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge rclk); #1;
      chk("rst.empty", int'(rempty), 1);
      chk("rst.valid", int'(out_valid), 0);
      chk("rst.rptr", int'(rptr), 0);
      chk("rst.level", int'(rlevel), 0);
    end

    // ---- directed vectors ---------------------------------------------------
    for (int i = 0; i < 18; i++) begin
      if (vt[i].rst_before != 0) do_reset();
      rq2_wptr  = gray(vt[i].wbin);
      out_ready = vt[i].rdy;
      @(posedge rclk); #1;
      chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(vt[i].e_valid));
      if (vt[i].e_valid) chk($sformatf("vec%0d.data", i), int'(out_data), int'(vt[i].e_data));
      chk($sformatf("vec%0d.empty", i), int'(rempty), int'(vt[i].e_empty));
      chk($sformatf("vec%0d.level", i), int'(rlevel), int'(vt[i].e_level));
      chk($sformatf("vec%0d.rptr", i), int'(rptr), int'(vt[i].e_rptr));
    end

    // ---- random traffic across the pointer wrap ---------------------------
    do_reset();
    begin
      int cyc;
      cyc = 0;
      while (m_fetched < 40 && cyc < 3000) begin
        if ($urandom_range(0, 2) != 0 && (m_wr - m_fetched) < DEPTH && m_wr < 40)
          do_write(8'($urandom));
        rstep(1'($urandom_range(0, 1)), "rand");
        if (int'(rlevel) > DEPTH) chk("rand.level_max", int'(rlevel), DEPTH);
        cyc++;
      end
      if (m_fetched < 40) chk("rand.timeout", m_fetched, 40);
      // drain the last word out of the output register
      rstep(1'b1, "rand_drain");
    end

    // ---- asynchronous reset mid-stream ------------------------------------
    do_reset();
    for (int i = 0; i < 5; i++) do_write(8'($urandom));
    rstep(1'b0, "pre");
    rstep(1'b0, "pre");
    chk("arst.pre_valid", int'(out_valid), 1);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("arst.valid", int'(out_valid), 0);
    chk("arst.empty", int'(rempty), 1);
    chk("arst.rptr", int'(rptr), 0);
    chk("arst.raddr", int'(raddr), 0);
    chk("arst.level", int'(rlevel), 0);
    rq2_wptr = '0;
    model_reset();
    @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    do_write(8'h5A);
    do_write(8'h5B);
    rstep(1'b1, "post");
    rstep(1'b1, "post");
    chk("arst.first_word", int'(out_data), 8'h5A);
    rstep(1'b1, "post");
    rstep(1'b1, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
